// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a multi-cycle
// mul/div occupancy counter that drives the PC / IF/ID stall line.
module idex_stage_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CTRL_W = 8,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IFIDop1,
  input  logic [REG_AW-1:0] IFIDop2,
  input  logic [DATA_W-1:0] ID_rd1,
  input  logic [DATA_W-1:0] ID_rd2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic [1:0]        ID_regWrite,
  input  logic              ID_memRead,
  input  logic              ID_isMulDiv,
  input  logic              flush,
  output logic [REG_AW-1:0] IDEXop1,
  output logic [REG_AW-1:0] IDEXop2,
  output logic [DATA_W-1:0] IDEXrd1,
  output logic [DATA_W-1:0] IDEXrd2,
  output logic [DATA_W-1:0] IDEXimm,
  output logic [CTRL_W-1:0] IDEXctrl,
  output logic [1:0]        IDEXregWrite,
  output logic              IDEXmemRead,
  output logic              IDEXisMulDiv,
  output logic              stall,
  output logic              md_busy
);

  // MD_LAT=1 would give a zero-width counter; keep one bit that stays 0.
  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] op1;
    logic [REG_AW-1:0] op2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        reg_write;
    logic              mem_read;
    logic              is_mul_div;
  } idex_t;

  idex_t      r_ex;
  logic [CNT_W-1:0] r_md_cnt;
  md_state_t  r_md_state;

  idex_t w_id;
  logic  w_load_use;
  logic  w_md_busy;

  assign w_id = '{op1: IFIDop1, op2: IFIDop2, rd1: ID_rd1, rd2: ID_rd2,
                  imm: ID_imm, ctrl: ID_ctrl, reg_write: ID_regWrite,
                  mem_read: ID_memRead, is_mul_div: ID_isMulDiv};

  // Loads only ever write op1, so only IDEXop1 can be a pending load target.
  assign w_load_use = r_ex.mem_read && (r_ex.reg_write != 2'b00) &&
                      (r_ex.op1 != '0) &&
                      ((IFIDop1 == r_ex.op1) || (IFIDop2 == r_ex.op1));

  assign w_md_busy = (r_md_state == MD_BUSY);
  assign stall     = (w_md_busy || w_load_use) && !flush;
  assign md_busy   = w_md_busy;

  // NOTE: asynchronous active-low reset clears every state bit; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex       <= '0;
      r_md_cnt   <= '0;
      r_md_state <= MD_IDLE;
    end else if (flush) begin
      r_ex       <= '0;
      r_md_cnt   <= '0;
      r_md_state <= MD_IDLE;
    end else if (r_md_state == MD_BUSY) begin
      r_md_cnt <= r_md_cnt - 1'b1;
      if (r_md_cnt == CNT_W'(1)) r_md_state <= MD_IDLE;
    end else if (w_load_use) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_id;
      if (w_id.is_mul_div && (MD_LAT > 1)) begin
        r_md_cnt   <= CNT_W'(MD_LAT - 1);
        r_md_state <= MD_BUSY;
      end
    end
  end

  assign IDEXop1      = r_ex.op1;
  assign IDEXop2      = r_ex.op2;
  assign IDEXrd1      = r_ex.rd1;
  assign IDEXrd2      = r_ex.rd2;
  assign IDEXimm      = r_ex.imm;
  assign IDEXctrl     = r_ex.ctrl;
  assign IDEXregWrite = r_ex.reg_write;
  assign IDEXmemRead  = r_ex.mem_read;
  assign IDEXisMulDiv = r_ex.is_mul_div;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg: directed hazard scenarios plus a
// randomized run against an instruction-level reference model.
module tb_idex_stage_reg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int CTRL_W = 8;
  localparam int MD_LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] IFIDop1, IFIDop2;
  logic [DATA_W-1:0] ID_rd1, ID_rd2, ID_imm;
  logic [CTRL_W-1:0] ID_ctrl;
  logic [1:0]        ID_regWrite;
  logic              ID_memRead, ID_isMulDiv, flush;
  logic [REG_AW-1:0] IDEXop1, IDEXop2;
  logic [DATA_W-1:0] IDEXrd1, IDEXrd2, IDEXimm;
  logic [CTRL_W-1:0] IDEXctrl;
  logic [1:0]        IDEXregWrite;
  logic              IDEXmemRead, IDEXisMulDiv, stall, md_busy;

  always #5 clk = ~clk;

  idex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFIDop1(IFIDop1), .IFIDop2(IFIDop2), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2),
    .ID_imm(ID_imm), .ID_ctrl(ID_ctrl), .ID_regWrite(ID_regWrite),
    .ID_memRead(ID_memRead), .ID_isMulDiv(ID_isMulDiv), .flush(flush),
    .IDEXop1(IDEXop1), .IDEXop2(IDEXop2), .IDEXrd1(IDEXrd1), .IDEXrd2(IDEXrd2),
    .IDEXimm(IDEXimm), .IDEXctrl(IDEXctrl), .IDEXregWrite(IDEXregWrite),
    .IDEXmemRead(IDEXmemRead), .IDEXisMulDiv(IDEXisMulDiv),
    .stall(stall), .md_busy(md_busy)
  );

  typedef struct packed {
    logic [REG_AW-1:0] op1, op2;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        rw;
    logic              mr, md;
  } instr_t;

  // Model: the instruction sitting in EX and how many more cycles it occupies EX.
  instr_t m_ex;
  int     m_busy_left;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic instr_t id_now();
    return '{IFIDop1, IFIDop2, ID_rd1, ID_rd2, ID_imm, ID_ctrl, ID_regWrite, ID_memRead, ID_isMulDiv};
  endfunction

  function automatic instr_t dut_ex();
    return '{IDEXop1, IDEXop2, IDEXrd1, IDEXrd2, IDEXimm, IDEXctrl, IDEXregWrite, IDEXmemRead, IDEXisMulDiv};
  endfunction

  function automatic logic m_load_use();
    return m_ex.mr && (m_ex.rw != 2'b00) && (m_ex.op1 != 0) &&
           ((IFIDop1 == m_ex.op1) || (IFIDop2 == m_ex.op1));
  endfunction

  function automatic logic m_stall();
    return ((m_busy_left > 0) || m_load_use()) && !flush;
  endfunction

  task automatic cycle();
    instr_t nx = m_ex;
    int     nb = m_busy_left;
    if (!rst_n)                begin nx = '0; nb = 0; end
    else if (flush)            begin nx = '0; nb = 0; end
    else if (m_busy_left > 0)  nb = m_busy_left - 1;
    else if (m_load_use())     nx = '0;
    else begin
      nx = id_now();
      nb = nx.md ? MD_LAT - 1 : 0;
    end
    @(posedge clk);
    #1;
    m_ex = nx;
    m_busy_left = nb;
  endtask

  task automatic set_id(input logic [REG_AW-1:0] op1, input logic [REG_AW-1:0] op2,
                        input logic [1:0] rw, input logic mr, input logic md);
    IFIDop1 = op1; IFIDop2 = op2; ID_regWrite = rw; ID_memRead = mr; ID_isMulDiv = md;
    ID_rd1 = DATA_W'($urandom); ID_rd2 = DATA_W'($urandom);
    ID_imm = DATA_W'($urandom); ID_ctrl = CTRL_W'($urandom);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    set_id(0, 0, 2'b00, 1'b0, 1'b0);
    m_ex = '0; m_busy_left = 0;
    n_checks++;
    if (dut_ex() !== '0 || stall !== 1'b0 || md_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_init: ex=%h stall=%b md_busy=%b required all 0", dut_ex(), stall, md_busy);
    end
    @(negedge clk); rst_n = 1'b1;
    // Start a mul/div and hit reset during its second BUSY cycle.
    set_id(2, 5, 2'b01, 1'b0, 1'b1);
    cycle();
    set_id(7, 8, 2'b01, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (md_busy !== 1'b1 || IDEXop1 !== 4'd2) begin
      n_errors++; $display("FAIL reset_pre_busy: md_busy=%b op1=%0d required 1 and 2", md_busy, IDEXop1);
    end
    #2 rst_n = 1'b0;
    #1;
    m_ex = '0; m_busy_left = 0;
    n_checks++;
    if (dut_ex() !== '0 || stall !== 1'b0 || md_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_busy: ex=%h stall=%b md_busy=%b required all 0", dut_ex(), stall, md_busy);
    end
    @(negedge clk); rst_n = 1'b1;
    set_id(1, 2, 2'b01, 1'b0, 1'b0);
    begin
      instr_t want = id_now();
      cycle();
      n_checks++;
      if (dut_ex() !== want || md_busy !== 1'b0) begin
        n_errors++; $display("FAIL reset_release_capture: ex=%h required %h md_busy=%b", dut_ex(), want, md_busy);
      end
    end
  endtask

  task automatic test_load_use();
    set_id(3, 1, 2'b01, 1'b1, 1'b0);   // lw R3
    cycle();
    set_id(4, 3, 2'b01, 1'b0, 1'b0);   // add R4,R3 reads R3 via op2
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++; $display("FAIL load_use_stall: stall=%b required 1", stall);
    end
    cycle();
    n_checks++;
    if (dut_ex() !== '0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL load_use_bubble: ex=%h stall=%b required 0 and 0", dut_ex(), stall);
    end
    begin
      instr_t want = id_now();
      cycle();
      n_checks++;
      if (dut_ex() !== want || IDEXop2 !== 4'd3) begin
        n_errors++; $display("FAIL load_use_retry: ex=%h required %h", dut_ex(), want);
      end
    end
  endtask

  task automatic test_load_r0();
    set_id(0, 1, 2'b01, 1'b1, 1'b0);   // lw R0
    cycle();
    set_id(0, 0, 2'b01, 1'b0, 1'b0);
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL load_r0_stall: stall=%b required 0", stall);
    end
    begin
      instr_t want = id_now();
      cycle();
      n_checks++;
      if (dut_ex() !== want) begin
        n_errors++; $display("FAIL load_r0_capture: ex=%h required %h", dut_ex(), want);
      end
    end
  endtask

  task automatic test_muldiv();
    set_id(2, 5, 2'b01, 1'b0, 1'b1);   // mul R2,R5
    cycle();
    set_id(7, 8, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < MD_LAT - 1; i++) begin
      n_checks++;
      if (stall !== 1'b1 || md_busy !== 1'b1 || IDEXop1 !== 4'd2 || IDEXop2 !== 4'd5) begin
        n_errors++; $display("FAIL muldiv_hold[%0d]: stall=%b md_busy=%b op1=%0d op2=%0d required 1 1 2 5",
                             i, stall, md_busy, IDEXop1, IDEXop2);
      end
      cycle();
    end
    n_checks++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_errors++; $display("FAIL muldiv_release: stall=%b md_busy=%b required 0 0", stall, md_busy);
    end
    cycle();
    n_checks++;
    if (IDEXop1 !== 4'd7 || IDEXop2 !== 4'd8 || IDEXisMulDiv !== 1'b0) begin
      n_errors++; $display("FAIL muldiv_next_capture: op1=%0d op2=%0d required 7 8", IDEXop1, IDEXop2);
    end
  endtask

  task automatic test_flush();
    set_id(2, 5, 2'b01, 1'b0, 1'b1);
    cycle();
    cycle();                            // now in the 2nd BUSY cycle
    flush = 1'b1; #1;
    n_checks++;
    if (stall !== 1'b0 || md_busy !== 1'b1) begin
      n_errors++; $display("FAIL flush_stall: stall=%b md_busy=%b required 0 1", stall, md_busy);
    end
    cycle();
    flush = 1'b0;
    set_id(0, 0, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (dut_ex() !== '0 || md_busy !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL flush_bubble: ex=%h md_busy=%b stall=%b required 0 0 0", dut_ex(), md_busy, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic stall_seen = 1'b0;
    set_id(3, 6, 2'b10, 1'b0, 1'b0);   // swap R3,R6
    stall_seen |= stall;
    cycle();
    n_checks++;
    if (IDEXregWrite !== 2'b10 || IDEXop1 !== 4'd3 || IDEXop2 !== 4'd6) begin
      n_errors++; $display("FAIL b2b_swap: rw=%b op1=%0d op2=%0d required 10 3 6", IDEXregWrite, IDEXop1, IDEXop2);
    end
    set_id(3, 6, 2'b01, 1'b0, 1'b0);   // add R3,R6
    stall_seen |= stall;
    cycle();
    stall_seen |= stall;
    n_checks++;
    if (IDEXregWrite !== 2'b01 || stall_seen !== 1'b0) begin
      n_errors++; $display("FAIL b2b_add: rw=%b stall_seen=%b required 01 0", IDEXregWrite, stall_seen);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 9) == 0);
      set_id(REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
             2'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
      n_checks++;
      if (stall !== m_stall() || md_busy !== (m_busy_left != 0) || dut_ex() !== m_ex) begin
        n_errors++; $display("FAIL random[%0d]: stall=%b md_busy=%b ex=%h required %b %b %h",
                             n, stall, md_busy, dut_ex(), m_stall(), (m_busy_left != 0), m_ex);
      end
      cycle();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_r0();
    test_muldiv();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
